// File: rtl/axi_rd_responder_if.sv
// AXI4 read address/data channel bundle between a read master and axi_rd_responder.
interface axi_rd_responder_if #(
  parameter int ADDR_BITS       = 32,
  parameter int DATA_WIDTH      = 8,
  parameter int BURST_LEN_WIDTH = 8,
  parameter int TID_WIDTH       = 8
) ();
  logic                       s_ar_valid;
  logic                       s_ar_ready;
  logic [ADDR_BITS-1:0]       s_ar_addr;
  logic [BURST_LEN_WIDTH-1:0] s_ar_len;
  logic [TID_WIDTH-1:0]       s_ar_id;
  logic                       s_r_valid;
  logic                       s_r_ready;
  logic [DATA_WIDTH-1:0]      s_r_data;
  logic [TID_WIDTH-1:0]       s_r_id;
  logic                       s_r_last;

  modport master (
    output s_ar_valid, s_ar_addr, s_ar_len, s_ar_id, s_r_ready,
    input  s_ar_ready, s_r_valid, s_r_data, s_r_id, s_r_last
  );

  modport slave (
    input  s_ar_valid, s_ar_addr, s_ar_len, s_ar_id, s_r_ready,
    output s_ar_ready, s_r_valid, s_r_data, s_r_id, s_r_last
  );
endinterface

// File: rtl/axi_rd_responder.sv
// AXI4 read responder: in-order AR queue with per-request latency countdown,
// INCR bursts served from a preloadable word memory.
module axi_rd_responder #(
  parameter int ADDR_BITS            = 32,
  parameter int LOG_BLOCK_DATA_BYTES = 0,
  parameter int MEM_LOG_DEPTH        = 10,
  parameter int LOG_QUEUE_SIZE       = 2,
  parameter int BURST_LEN_WIDTH      = 8,
  parameter int TID_WIDTH            = 8,
  parameter int LAT_WIDTH            = 8,
  localparam int DATA_WIDTH          = 8 << LOG_BLOCK_DATA_BYTES
) (
  input  logic                      clk,
  input  logic                      resetN,
  axi_rd_responder_if.slave         bus,
  input  logic [LAT_WIDTH-1:0]      latency,
  input  logic                      pl_wr_en,
  input  logic [MEM_LOG_DEPTH-1:0]  pl_wr_addr,
  input  logic [DATA_WIDTH-1:0]     pl_wr_data,
  output logic [LOG_QUEUE_SIZE:0]   outstanding
);

  localparam int QD    = 1 << LOG_QUEUE_SIZE;
  localparam int QW    = LOG_QUEUE_SIZE;
  localparam int CW    = LOG_QUEUE_SIZE + 1;
  localparam int DEPTH = 1 << MEM_LOG_DEPTH;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  logic [DATA_WIDTH-1:0]      mem_r [DEPTH];

  logic [TID_WIDTH-1:0]       q_id_r  [QD];
  logic [MEM_LOG_DEPTH-1:0]   q_idx_r [QD];
  logic [BURST_LEN_WIDTH-1:0] q_len_r [QD];
  logic [LAT_WIDTH-1:0]       q_cnt_r [QD];
  logic [QW-1:0]              wr_ptr_r;
  logic [QW-1:0]              rd_ptr_r;
  logic [CW-1:0]              count_r;
  logic [CW-1:0]              count_nxt_s;
  logic [QD-1:0]              q_valid_s;
  logic [QW-1:0]              q_off_s;
  logic [MEM_LOG_DEPTH-1:0]   ar_idx_s;
  logic                       full_s;
  logic                       push_s;
  logic                       pop_s;

  state_t                     state_r;
  state_t                     state_nxt_s;
  logic [MEM_LOG_DEPTH-1:0]   beat_idx_r;
  logic [MEM_LOG_DEPTH-1:0]   beat_idx_nxt_s;
  logic [BURST_LEN_WIDTH-1:0] remain_r;
  logic [BURST_LEN_WIDTH-1:0] remain_nxt_s;
  logic [TID_WIDTH-1:0]       id_r;
  logic [TID_WIDTH-1:0]       id_nxt_s;
  logic [CW-1:0]              outstanding_r;

  // Queue occupancy, per-entry validity and AR acceptance.
  always_comb begin
    full_s    = (count_r == CW'(QD));
    push_s    = bus.s_ar_valid && !full_s;
    ar_idx_s  = MEM_LOG_DEPTH'(bus.s_ar_addr >> LOG_BLOCK_DATA_BYTES);
    q_off_s   = '0;
    q_valid_s = '0;
    for (int i = 0; i < QD; i++) begin
      // Entry i is live when its distance from the head is below the count.
      q_off_s      = QW'(i) - rd_ptr_r;
      q_valid_s[i] = ({1'b0, q_off_s} < count_r);
    end
  end

  // Burst FSM next state, beat counters and head pop decision.
  always_comb begin
    state_nxt_s    = state_r;
    beat_idx_nxt_s = beat_idx_r;
    remain_nxt_s   = remain_r;
    id_nxt_s       = id_r;
    pop_s          = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if ((count_r != '0) && (q_cnt_r[rd_ptr_r] == '0)) begin
          pop_s          = 1'b1;
          state_nxt_s    = ST_BURST;
          beat_idx_nxt_s = q_idx_r[rd_ptr_r];
          remain_nxt_s   = q_len_r[rd_ptr_r];
          id_nxt_s       = q_id_r[rd_ptr_r];
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (bus.s_r_ready) begin
          beat_idx_nxt_s = beat_idx_r + MEM_LOG_DEPTH'(1);
          remain_nxt_s   = remain_r - BURST_LEN_WIDTH'(1);
          if (remain_r == '0) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_BURST;
          end
        end else begin
          state_nxt_s = ST_BURST;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    count_nxt_s = count_r + CW'(push_s) - CW'(pop_s);
  end

  // Queue pointers, entry payloads and parallel latency countdown.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < QD; i++) begin
        q_id_r[i]  <= '0;
        q_idx_r[i] <= '0;
        q_len_r[i] <= '0;
        q_cnt_r[i] <= '0;
      end
    end else begin
      count_r <= count_nxt_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + QW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + QW'(1);
      end
      for (int i = 0; i < QD; i++) begin
        if (push_s && (wr_ptr_r == QW'(i))) begin
          q_id_r[i]  <= bus.s_ar_id;
          q_idx_r[i] <= ar_idx_s;
          q_len_r[i] <= bus.s_ar_len;
          q_cnt_r[i] <= latency;
        end else if (q_valid_s[i] && (q_cnt_r[i] != '0)) begin
          q_cnt_r[i] <= q_cnt_r[i] - LAT_WIDTH'(1);
        end
      end
    end
  end

  // Burst FSM state, beat pointer, latched ID and outstanding counter.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r       <= ST_IDLE;
      beat_idx_r    <= '0;
      remain_r      <= '0;
      id_r          <= '0;
      outstanding_r <= '0;
    end else begin
      state_r       <= state_nxt_s;
      beat_idx_r    <= beat_idx_nxt_s;
      remain_r      <= remain_nxt_s;
      id_r          <= id_nxt_s;
      outstanding_r <= count_nxt_s + CW'(state_nxt_s == ST_BURST);
    end
  end

  // Preload write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (pl_wr_en) begin
      mem_r[pl_wr_addr] <= pl_wr_data;
    end
  end

  assign bus.s_ar_ready = !full_s;
  assign bus.s_r_valid  = (state_r == ST_BURST);
  assign bus.s_r_last   = (state_r == ST_BURST) && (remain_r == '0);
  assign bus.s_r_id     = id_r;
  assign bus.s_r_data   = mem_r[beat_idx_r];
  assign outstanding    = outstanding_r;

endmodule

// File: tb/tb_axi_rd_responder.sv
// Directed self-checking bench for axi_rd_responder (default parameters, 8-bit beats).
module tb_axi_rd_responder;

  logic       clk;
  logic       resetN;
  logic [7:0] latency;
  logic       pl_wr_en;
  logic [9:0] pl_wr_addr;
  logic [7:0] pl_wr_data;
  logic [2:0] outstanding;
  int         pass_cnt;
  int         total_cnt;

  axi_rd_responder_if #(
    .ADDR_BITS(32), .DATA_WIDTH(8), .BURST_LEN_WIDTH(8), .TID_WIDTH(8)
  ) bus ();

  axi_rd_responder dut (
    .clk         (clk),
    .resetN      (resetN),
    .bus         (bus),
    .latency     (latency),
    .pl_wr_en    (pl_wr_en),
    .pl_wr_addr  (pl_wr_addr),
    .pl_wr_data  (pl_wr_data),
    .outstanding (outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [7:0] d);
    pl_wr_en = 1'b1; pl_wr_addr = a; pl_wr_data = d;
    tick;
    pl_wr_en = 1'b0;
  endtask

  task automatic ar_issue(input logic [31:0] a, input logic [7:0] len, input logic [7:0] id,
                          input logic [7:0] lat);
    bus.s_ar_addr = a; bus.s_ar_len = len; bus.s_ar_id = id; latency = lat;
    bus.s_ar_valid = 1'b1;
    tick;
    bus.s_ar_valid = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int cycles);
    cycles = 0;
    while (!bus.s_r_valid && cycles < limit) begin
      tick;
      cycles++;
    end
  endtask

  task automatic test_reset;
    resetN = 1'b0;
    tick; tick;
    total_cnt++; if (bus.s_r_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.s_r_valid); else pass_cnt++;
    total_cnt++; if (bus.s_r_last !== 1'b0) $display("FAIL reset_last: got %b want 0", bus.s_r_last); else pass_cnt++;
    total_cnt++; if (bus.s_r_id !== 8'h00) $display("FAIL reset_id: got %h want 00", bus.s_r_id); else pass_cnt++;
    total_cnt++; if (outstanding !== 3'd0) $display("FAIL reset_outstanding: got %0d want 0", outstanding); else pass_cnt++;
    resetN = 1'b1;
    tick;
    total_cnt++; if (bus.s_ar_ready !== 1'b1) $display("FAIL reset_ar_ready: got %b want 1", bus.s_ar_ready); else pass_cnt++;
  endtask

  task automatic test_latency;
    int cyc;
    preload(10'h010, 8'hA5);
    bus.s_r_ready = 1'b1;
    ar_issue(32'h10, 8'd0, 8'd5, 8'd3);
    total_cnt++; if (outstanding !== 3'd1) $display("FAIL lat_outstanding_q: got %0d want 1", outstanding); else pass_cnt++;
    wait_valid(20, cyc);
    total_cnt++; if (cyc !== 4) $display("FAIL lat_cycles: got %0d want 4", cyc); else pass_cnt++;
    total_cnt++; if (bus.s_r_data !== 8'hA5) $display("FAIL lat_data: got %h want a5", bus.s_r_data); else pass_cnt++;
    total_cnt++; if (bus.s_r_id !== 8'd5) $display("FAIL lat_id: got %0d want 5", bus.s_r_id); else pass_cnt++;
    total_cnt++; if (bus.s_r_last !== 1'b1) $display("FAIL lat_last: got %b want 1", bus.s_r_last); else pass_cnt++;
    total_cnt++; if (outstanding !== 3'd1) $display("FAIL lat_outstanding_b: got %0d want 1", outstanding); else pass_cnt++;
    tick;
    total_cnt++; if (bus.s_r_valid !== 1'b0) $display("FAIL lat_end_valid: got %b want 0", bus.s_r_valid); else pass_cnt++;
    total_cnt++; if (outstanding !== 3'd0) $display("FAIL lat_end_outstanding: got %0d want 0", outstanding); else pass_cnt++;
  endtask

  task automatic test_stall;
    int cyc;
    logic [7:0] exp_d;
    for (int a = 0; a < 4; a++) preload(10'(10'h020 + a), 8'(a + 1));
    bus.s_r_ready = 1'b0;
    ar_issue(32'h20, 8'd3, 8'd7, 8'd0);
    wait_valid(20, cyc);
    total_cnt++; if (cyc !== 1) $display("FAIL stall_cycles: got %0d want 1", cyc); else pass_cnt++;
    for (int b = 0; b < 4; b++) begin
      exp_d = 8'(b + 1);
      total_cnt++; if (bus.s_r_valid !== 1'b1 || bus.s_r_data !== exp_d || bus.s_r_last !== (b == 3))
        $display("FAIL stall_beat%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", b, bus.s_r_valid, bus.s_r_data, bus.s_r_last, exp_d, (b == 3));
      else pass_cnt++;
      bus.s_r_ready = 1'b0;
      tick;
      total_cnt++; if (bus.s_r_valid !== 1'b1 || bus.s_r_data !== exp_d || bus.s_r_id !== 8'd7 || bus.s_r_last !== (b == 3))
        $display("FAIL stall_hold%0d: got v=%b d=%h id=%0d l=%b want v=1 d=%h id=7", b, bus.s_r_valid, bus.s_r_data, bus.s_r_id, bus.s_r_last, exp_d);
      else pass_cnt++;
      bus.s_r_ready = 1'b1;
      tick;
      bus.s_r_ready = 1'b0;
    end
    total_cnt++; if (bus.s_r_valid !== 1'b0) $display("FAIL stall_end_valid: got %b want 0", bus.s_r_valid); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int cyc;
    logic [7:0] exp_d;
    for (int a = 8'h42; a <= 8'h4B; a++) preload(10'(a), 8'(a));
    latency = 8'd8; bus.s_r_ready = 1'b0; bus.s_ar_len = 8'd1; bus.s_ar_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      bus.s_ar_addr = 32'(32'h40 + 2 * i);
      bus.s_ar_id   = 8'(i);
      if (i < 5) tick;
    end
    total_cnt++; if (bus.s_ar_ready !== 1'b0) $display("FAIL b2b_full_ready: got %b want 0", bus.s_ar_ready); else pass_cnt++;
    total_cnt++; if (outstanding !== 3'd4) $display("FAIL b2b_full_outstanding: got %0d want 4", outstanding); else pass_cnt++;
    tick; tick;
    total_cnt++; if (bus.s_ar_ready !== 1'b0) $display("FAIL b2b_held_ready: got %b want 0", bus.s_ar_ready); else pass_cnt++;
    bus.s_r_ready = 1'b1;
    wait_valid(30, cyc);
    total_cnt++; if (cyc !== 4) $display("FAIL b2b_first_cycles: got %0d want 4", cyc); else pass_cnt++;
    total_cnt++; if (bus.s_ar_ready !== 1'b1) $display("FAIL b2b_reopen_ready: got %b want 1", bus.s_ar_ready); else pass_cnt++;
    for (int k = 1; k <= 5; k++) begin
      for (int j = 0; j < 2; j++) begin
        exp_d = 8'(8'h40 + 2 * k + j);
        total_cnt++; if (bus.s_r_valid !== 1'b1 || bus.s_r_id !== 8'(k) || bus.s_r_data !== exp_d || bus.s_r_last !== (j == 1))
          $display("FAIL b2b_beat%0d_%0d: got v=%b id=%0d d=%h l=%b want v=1 id=%0d d=%h l=%b", k, j,
                   bus.s_r_valid, bus.s_r_id, bus.s_r_data, bus.s_r_last, k, exp_d, (j == 1));
        else pass_cnt++;
        tick;
        bus.s_ar_valid = 1'b0;
      end
      if (k < 5) begin
        total_cnt++; if (bus.s_r_valid !== 1'b0) $display("FAIL b2b_bubble%0d: got %b want 0", k, bus.s_r_valid); else pass_cnt++;
        tick;
      end
    end
    total_cnt++; if (bus.s_r_valid !== 1'b0 || outstanding !== 3'd0)
      $display("FAIL b2b_end: got v=%b out=%0d want v=0 out=0", bus.s_r_valid, outstanding);
    else pass_cnt++;
  endtask

  task automatic test_wrap;
    int cyc;
    logic [7:0] exp_d;
    preload(10'h3FE, 8'hE0); preload(10'h3FF, 8'hE1); preload(10'h000, 8'hE2); preload(10'h001, 8'hE3);
    bus.s_r_ready = 1'b1;
    ar_issue(32'h3FE, 8'd3, 8'h21, 8'd0);
    wait_valid(20, cyc);
    total_cnt++; if (cyc !== 1) $display("FAIL wrap_cycles: got %0d want 1", cyc); else pass_cnt++;
    for (int j = 0; j < 4; j++) begin
      exp_d = 8'(8'hE0 + j);
      total_cnt++; if (bus.s_r_valid !== 1'b1 || bus.s_r_data !== exp_d || bus.s_r_last !== (j == 3))
        $display("FAIL wrap_beat%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", j, bus.s_r_valid, bus.s_r_data, bus.s_r_last, exp_d, (j == 3));
      else pass_cnt++;
      tick;
    end
    total_cnt++; if (bus.s_r_valid !== 1'b0) $display("FAIL wrap_end_valid: got %b want 0", bus.s_r_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid_burst;
    int cyc;
    logic [7:0] exp_d;
    for (int a = 0; a < 8; a++) preload(10'(10'h100 + a), 8'(8'h80 + a));
    bus.s_r_ready = 1'b1;
    ar_issue(32'h100, 8'd7, 8'd9, 8'd0);
    ar_issue(32'h180, 8'd0, 8'd10, 8'd0);
    ar_issue(32'h181, 8'd0, 8'd11, 8'd0);
    tick;
    total_cnt++; if (bus.s_r_data !== 8'h82 || outstanding !== 3'd3)
      $display("FAIL rst_mid_pre: got d=%h out=%0d want d=82 out=3", bus.s_r_data, outstanding);
    else pass_cnt++;
    resetN = 1'b0;
    #1;
    total_cnt++; if (bus.s_r_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", bus.s_r_valid); else pass_cnt++;
    total_cnt++; if (outstanding !== 3'd0) $display("FAIL rst_mid_outstanding: got %0d want 0", outstanding); else pass_cnt++;
    tick;
    resetN = 1'b1;
    ar_issue(32'h100, 8'd2, 8'd3, 8'd0);
    wait_valid(20, cyc);
    total_cnt++; if (cyc !== 1) $display("FAIL rst_after_cycles: got %0d want 1", cyc); else pass_cnt++;
    for (int j = 0; j < 3; j++) begin
      exp_d = 8'(8'h80 + j);
      total_cnt++; if (bus.s_r_valid !== 1'b1 || bus.s_r_id !== 8'd3 || bus.s_r_data !== exp_d || bus.s_r_last !== (j == 2))
        $display("FAIL rst_after_beat%0d: got v=%b id=%0d d=%h l=%b want v=1 id=3 d=%h", j, bus.s_r_valid, bus.s_r_id, bus.s_r_data, bus.s_r_last, exp_d);
      else pass_cnt++;
      tick;
    end
    tick; tick;
    total_cnt++; if (bus.s_r_valid !== 1'b0 || outstanding !== 3'd0)
      $display("FAIL rst_after_end: got v=%b out=%0d want v=0 out=0", bus.s_r_valid, outstanding);
    else pass_cnt++;
  endtask

  task automatic test_in_order;
    int cyc;
    preload(10'h200, 8'h31); preload(10'h201, 8'h32); preload(10'h210, 8'h41);
    bus.s_r_ready = 1'b1;
    ar_issue(32'h200, 8'd1, 8'h0A, 8'd10);
    ar_issue(32'h210, 8'd0, 8'h0B, 8'd0);
    total_cnt++; if (outstanding !== 3'd2 || bus.s_r_valid !== 1'b0)
      $display("FAIL order_queued: got out=%0d v=%b want out=2 v=0", outstanding, bus.s_r_valid);
    else pass_cnt++;
    wait_valid(30, cyc);
    total_cnt++; if (cyc !== 10) $display("FAIL order_a_cycles: got %0d want 10", cyc); else pass_cnt++;
    total_cnt++; if (bus.s_r_id !== 8'h0A || bus.s_r_data !== 8'h31 || bus.s_r_last !== 1'b0)
      $display("FAIL order_a0: got id=%h d=%h l=%b want id=0a d=31 l=0", bus.s_r_id, bus.s_r_data, bus.s_r_last);
    else pass_cnt++;
    tick;
    total_cnt++; if (bus.s_r_id !== 8'h0A || bus.s_r_data !== 8'h32 || bus.s_r_last !== 1'b1)
      $display("FAIL order_a1: got id=%h d=%h l=%b want id=0a d=32 l=1", bus.s_r_id, bus.s_r_data, bus.s_r_last);
    else pass_cnt++;
    tick;
    total_cnt++; if (bus.s_r_valid !== 1'b0) $display("FAIL order_bubble: got %b want 0", bus.s_r_valid); else pass_cnt++;
    tick;
    total_cnt++; if (bus.s_r_valid !== 1'b1 || bus.s_r_id !== 8'h0B || bus.s_r_data !== 8'h41 || bus.s_r_last !== 1'b1)
      $display("FAIL order_b: got v=%b id=%h d=%h l=%b want v=1 id=0b d=41 l=1", bus.s_r_valid, bus.s_r_id, bus.s_r_data, bus.s_r_last);
    else pass_cnt++;
    tick;
    total_cnt++; if (bus.s_r_valid !== 1'b0 || outstanding !== 3'd0)
      $display("FAIL order_end: got v=%b out=%0d want v=0 out=0", bus.s_r_valid, outstanding);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    resetN = 1'b0; latency = 8'd0;
    pl_wr_en = 1'b0; pl_wr_addr = 10'd0; pl_wr_data = 8'd0;
    bus.s_ar_valid = 1'b0; bus.s_ar_addr = 32'd0; bus.s_ar_len = 8'd0; bus.s_ar_id = 8'd0;
    bus.s_r_ready = 1'b0;
    test_reset;
    test_latency;
    test_stall;
    test_back_to_back;
    test_wrap;
    test_reset_mid_burst;
    test_in_order;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
